fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of the 8-entry dual-clock buffer among NUM_REQ producers.
//  Sits entirely in the buffer's write-clock domain and drives its data_1 / data_1_en inputs directly.
//  Grants bursts of up to MAX_BURST words per requester and back-pressures on buffer_full.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  DATA_W     16  word width; matches buffer word width
//  MAX_BURST  4   max words per grant (1..16)
//  CNT_W      16  width of per-requester word counters (stats option only)
// PORTS
//  clock          in   1               write-domain clock, all logic on rising edge
//  reset_n        in   1               asynchronous, active-low reset
//  req_valid      in   NUM_REQ         requester i has a word on req_data slice i
//  req_data       in   NUM_REQ*DATA_W  packed words; slice i = [i*DATA_W +: DATA_W]
//  req_ready      out  NUM_REQ         word of requester i accepted this cycle
//  buffer_full    in   1               buffer full flag (write-domain view)
//  data_1         out  DATA_W          word to buffer
//  data_1_en      out  1               write strobe to buffer
//  grant_id       out  $clog2(NUM_REQ) currently/last granted requester
//  busy           out  1               state == BURST
//  stat_sel       in   $clog2(NUM_REQ) counter select (FIFO_WR_ARB_STATS_EN only)
//  stat_count     out  CNT_W           accepted-word count of stat_sel (FIFO_WR_ARB_STATS_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, grant_id=0, last_grant=NUM_REQ-1, burst_cnt=0; outputs req_ready=0, data_1_en=0, busy=0, data_1=0.
//  FSM IDLE: if any req_valid, pick first valid index after last_grant (wrap modulo NUM_REQ);
//    register grant_id, last_grant <= pick, burst_cnt <= 0, -> BURST. No transfer in IDLE.
//  FSM BURST (combinational transfer, no extra latency):
//    xfer = req_valid[grant_id] & ~buffer_full;
//    req_ready[grant_id] = xfer, other req_ready = 0; data_1_en = xfer;
//    data_1 = req_data slice grant_id when xfer, else 0.
//    On xfer: burst_cnt++; if burst_cnt == MAX_BURST-1 -> IDLE.
//    req_valid[grant_id] low -> IDLE next cycle, no transfer.
//    buffer_full high with valid -> hold grant, no transfer, burst_cnt unchanged (no timeout).
//  Latency: req_valid rise in IDLE -> first xfer one cycle later (if not full).
//  Steady throughput with all requesters valid: MAX_BURST words per MAX_BURST+1 cycles.
//  Fairness: a requester waits at most (NUM_REQ-1)*(MAX_BURST+1) non-full cycles after its valid.
//  Requester contract: req_data stable while req_valid high and not accepted; valid may drop only when not ready.
//  Single requester: re-granted to itself after each burst via the wrap rule.
//  buffer_full asserting in same cycle as last burst word: word not transferred, FSM stays in BURST.
//  reset_n low mid-burst: immediate return to reset values; partially sent burst is not resumed.
//  Arithmetic: burst_cnt width $clog2(MAX_BURST)+1, no overflow; index wrap by compare, not power-of-2 mask.
// CONFIGURATION
//  FIFO_WR_ARB_STATS_EN defined: NUM_REQ saturating CNT_W counters incremented on each xfer of owner;
//    cleared by reset_n; stat_count = counter[stat_sel], registered (1-cycle latency).
//  FIFO_WR_ARB_STATS_EN undefined: stat_sel/stat_count ports and counters absent; arbitration identical.
// STRUCTURE
//  Package fifo_wr_arb_pkg: state enum {IDLE, BURST}, DATA_W default, helper function for index wrap.
//  Sub-module rr_picker (NUM_REQ): valid vector + last_grant -> pick index + any_valid, combinational.
//  Top holds FSM, burst counter, output mux, stats generate block.
// TESTING
//  1 Reset: reset_n low with all req_valid=1 -> req_ready=0, data_1_en=0, grant_id=0, busy=0.
//  2 Req0 only, 6 words 0x1000..0x1005, MAX_BURST=4: idle gap, 4 writes, idle gap, 2 writes; data order preserved.
//  3 All 4 valid, constant, not full -> grant sequence 0,1,2,3,0; 4 words each; 1 gap cycle per burst.
//  4 buffer_full high 3 cycles mid-burst of req2 at word 2 -> data_1_en=0 for 3 cycles, grant_id=2, resumes at word 2.
//  5 Req1 drops valid after 1 word -> FSM IDLE next cycle, next grant goes to req2 (valid), not req1.
//  6 Stats on: 10 words req3 then stat_sel=3 -> stat_count=10 next cycle; reset_n pulse -> 0.

Source files
------------

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and helpers for the round-robin buffer write arbiter.
// The optional per-requester statistics are enabled by FIFO_WR_ARB_STATS_EN.
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   localparam int DATA_W_DEFAULT = 16;

   // Index wrap by comparison so non-power-of-two requester counts work.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index strictly after last_grant_i,
// wrapping modulo NUM_REQ, so last_grant_i itself is the lowest priority.
module rr_picker
   import fifo_wr_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [IDX_W-1:0]   last_grant_i,
   output logic [IDX_W-1:0]   pick_o,
   output logic               any_valid_o
);

   logic [IDX_W-1:0] idx;
   logic             found;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      pick_o = last_grant_i;
      found  = 1'b0;
      idx    = last_grant_i;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IDX_W'(wrap_inc(int'(idx), NUM_REQ));
         if (!found && valid_i[idx]) begin
            found  = 1'b1;
            pick_o = idx;
         end
      end
   end

   assign any_valid_o = |valid_i;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing the write port of the dual-clock buffer among NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester accepted-word counters (stat_sel/stat_count).
module fifo_write_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = DATA_W_DEFAULT,
   parameter  int MAX_BURST = 4,
   parameter  int CNT_W     = 16,
   localparam int IDX_W     = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      buffer_full,
   output logic [DATA_W-1:0]         data_1,
   output logic                      data_1_en,
   output logic [IDX_W-1:0]          grant_id,
`ifdef FIFO_WR_ARB_STATS_EN
   input  logic [IDX_W-1:0]          stat_sel,
   output logic [CNT_W-1:0]          stat_count,
`endif
   output logic                      busy
);

   localparam int           BW       = $clog2(MAX_BURST) + 1;
   localparam logic [BW-1:0] LAST_CNT = BW'(MAX_BURST - 1);

   state_e           state_q;
   logic [IDX_W-1:0] grant_id_q;
   logic [IDX_W-1:0] last_grant_q;
   logic [BW-1:0]    burst_cnt_q;

   logic [IDX_W-1:0] pick;
   logic             any_valid;
   logic             grant_valid;
   logic             xfer;

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .valid_i      (req_valid),
      .last_grant_i (last_grant_q),
      .pick_o       (pick),
      .any_valid_o  (any_valid)
   );

   assign grant_valid = req_valid[grant_id_q];
   // Transfer is combinational in BURST so a granted word moves with no extra cycle.
   assign xfer        = (state_q == BURST) && grant_valid && !buffer_full;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         burst_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_valid) begin
                  grant_id_q   <= pick;
                  last_grant_q <= pick;
                  burst_cnt_q  <= '0;
                  state_q      <= BURST;
               end
            end
            BURST: begin
               if (!grant_valid) begin
                  state_q <= IDLE;
               end else if (xfer) begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
                  if (burst_cnt_q == LAST_CNT) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = xfer ? (NUM_REQ'(1) << grant_id_q) : '0;
   assign data_1_en = xfer;
   assign data_1    = xfer ? req_data[grant_id_q*DATA_W +: DATA_W] : '0;
   assign grant_id  = grant_id_q;
   assign busy      = (state_q == BURST);

`ifdef FIFO_WR_ARB_STATS_EN
   logic [CNT_W-1:0] cnt_q [NUM_REQ];
   logic [CNT_W-1:0] stat_count_q;

   // NOTE: the counters are a handful of flops, not a RAM, so they take the async reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
         stat_count_q <= '0;
      end else begin
         if (xfer && (cnt_q[grant_id_q] != '1))
            cnt_q[grant_id_q] <= cnt_q[grant_id_q] + 1'b1;
         stat_count_q <= cnt_q[stat_sel];
      end
   end

   assign stat_count = stat_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
// Statistics scenario runs only when FIFO_WR_ARB_STATS_EN is defined.
module tb_fifo_write_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 16;
   localparam int MAX_BURST = 4;
   localparam int CNT_W     = 16;
   localparam int IDX_W     = 2;

   logic                      clock = 1'b0;
   logic                      reset_n;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      buffer_full;
   logic [DATA_W-1:0]         data_1;
   logic                      data_1_en;
   logic [IDX_W-1:0]          grant_id;
   logic                      busy;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [IDX_W-1:0]          stat_sel;
   logic [CNT_W-1:0]          stat_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   fifo_write_arbiter #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .buffer_full (buffer_full),
      .data_1      (data_1),
      .data_1_en   (data_1_en),
      .grant_id    (grant_id),
`ifdef FIFO_WR_ARB_STATS_EN
      .stat_sel    (stat_sel),
      .stat_count  (stat_count),
`endif
      .busy        (busy)
   );

   task automatic set_word(input int i, input logic [DATA_W-1:0] w);
      req_data[i*DATA_W +: DATA_W] = w;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset_n     = 1'b0;
      req_valid   = '0;
      req_data    = '0;
      buffer_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
      stat_sel    = '0;
`endif
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n     = 1'b0;
      req_valid   = '1;
      req_data    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      buffer_full = 1'b0;
      repeat (2) @(posedge clock);
      #2;
      n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
      n_vec++; if (data_1_en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0", data_1_en); end
      n_vec++; if (grant_id !== 2'd0) begin n_err++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if (data_1 !== 16'h0000) begin n_err++; $display("FAIL reset_data got=%h exp=0000", data_1); end
      req_valid = '0;
      #1;
      reset_n = 1'b1;
      next_cycle();
   endtask

   // Single requester, 6 words: gap, 4 writes, gap, 2 writes, then valid drops.
   task automatic test_single_req();
      logic [8:0] exp_en;
      int         n;
      logic       got;
      exp_en = 9'b011011110;
      n = 0;
      apply_reset();
      for (int c = 0; c < 9; c++) begin
         req_valid[0] = (n < 6);
         set_word(0, 16'(16'h1000 + n));
         #1;
         n_vec++; if (data_1_en !== exp_en[c]) begin n_err++; $display("FAIL single_en cyc=%0d got=%b exp=%b", c, data_1_en, exp_en[c]); end
         if (exp_en[c]) begin
            n_vec++; if (data_1 !== 16'(16'h1000 + n)) begin n_err++; $display("FAIL single_data cyc=%0d got=%h exp=%h", c, data_1, 16'(16'h1000 + n)); end
            n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_ready cyc=%0d got=%b exp=0001", c, req_ready); end
         end
         got = req_ready[0];
         next_cycle();
         if (got) n++;
      end
      n_vec++; if (n != 6) begin n_err++; $display("FAIL single_count got=%0d exp=6", n); end
      req_valid = '0;
   endtask

   // All four requesters valid: grants 0,1,2,3,0 with one idle cycle before each burst.
   task automatic test_round_robin();
      int         ph;
      int         exp_g;
      logic [3:0] exp_rdy;
      apply_reset();
      req_valid = '1;
      for (int i = 0; i < NUM_REQ; i++) set_word(i, 16'(16'hA000 + i));
      for (int c = 0; c < 25; c++) begin
         ph    = c % 5;
         exp_g = (c / 5) % 4;
         exp_rdy = 4'b0001 << exp_g;
         #1;
         if (ph == 0) begin
            n_vec++; if (data_1_en !== 1'b0) begin n_err++; $display("FAIL rr_gap_en cyc=%0d got=%b exp=0", c, data_1_en); end
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rr_gap_busy cyc=%0d got=%b exp=0", c, busy); end
         end else begin
            n_vec++; if (data_1_en !== 1'b1) begin n_err++; $display("FAIL rr_en cyc=%0d got=%b exp=1", c, data_1_en); end
            n_vec++; if (grant_id !== 2'(exp_g)) begin n_err++; $display("FAIL rr_grant cyc=%0d got=%0d exp=%0d", c, grant_id, exp_g); end
            n_vec++; if (data_1 !== 16'(16'hA000 + exp_g)) begin n_err++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", c, data_1, 16'(16'hA000 + exp_g)); end
            n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
         end
         next_cycle();
      end
      req_valid = '0;
   endtask

   // buffer_full for 3 cycles at word 2 of a req2 burst: grant held, resumes at word 2.
   task automatic test_full_stall();
      logic [8:0] exp_en;
      int         n;
      logic       got;
      exp_en = 9'b011000110;
      n = 0;
      apply_reset();
      for (int c = 0; c < 9; c++) begin
         req_valid[2] = (n < 4);
         set_word(2, 16'(16'h2000 + n));
         buffer_full = (c >= 3 && c <= 5);
         #1;
         n_vec++; if (data_1_en !== exp_en[c]) begin n_err++; $display("FAIL full_en cyc=%0d got=%b exp=%b", c, data_1_en, exp_en[c]); end
         if (c >= 3 && c <= 5) begin
            n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL full_grant cyc=%0d got=%0d exp=2", c, grant_id); end
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL full_busy cyc=%0d got=%b exp=1", c, busy); end
            n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL full_ready cyc=%0d got=%b exp=0000", c, req_ready); end
         end
         if (c == 6) begin
            n_vec++; if (data_1 !== 16'h2002) begin n_err++; $display("FAIL full_resume got=%h exp=2002", data_1); end
         end
         got = req_ready[2];
         next_cycle();
         if (got) n++;
      end
      buffer_full = 1'b0;
      n_vec++; if (n != 4) begin n_err++; $display("FAIL full_count got=%0d exp=4", n); end
      req_valid = '0;
   endtask

   // Req1 drops valid after one word; the next grant skips past req1 to req2.
   task automatic test_drop_valid();
      apply_reset();
      req_valid = 4'b0110;
      set_word(1, 16'h3100);
      set_word(2, 16'h3200);
      #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
      next_cycle();
      #1;
      n_vec++; if (grant_id !== 2'd1) begin n_err++; $display("FAIL drop_grant1 got=%0d exp=1", grant_id); end
      n_vec++; if (data_1 !== 16'h3100 || data_1_en !== 1'b1) begin n_err++; $display("FAIL drop_word1 got=%h/%b exp=3100/1", data_1, data_1_en); end
      next_cycle();
      req_valid = 4'b0100;
      #1;
      n_vec++; if (data_1_en !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL drop_nodata got en=%b busy=%b exp en=0 busy=1", data_1_en, busy); end
      next_cycle();
      req_valid = 4'b0110;
      #1;
      n_vec++; if (busy !== 1'b0 || data_1_en !== 1'b0) begin n_err++; $display("FAIL drop_idle got busy=%b en=%b exp 0/0", busy, data_1_en); end
      next_cycle();
      #1;
      n_vec++; if (grant_id !== 2'd2) begin n_err++; $display("FAIL drop_next_grant got=%0d exp=2", grant_id); end
      n_vec++; if (req_ready !== 4'b0100 || data_1 !== 16'h3200) begin n_err++; $display("FAIL drop_next_xfer got rdy=%b data=%h exp rdy=0100 data=3200", req_ready, data_1); end
      next_cycle();
      req_valid = '0;
   endtask

`ifdef FIFO_WR_ARB_STATS_EN
   // Ten words from req3, read back via stat_sel, then cleared by reset.
   task automatic test_stats();
      int   n;
      int   c;
      logic got;
      n = 0;
      c = 0;
      apply_reset();
      while (n < 10 && c < 60) begin
         req_valid[3] = 1'b1;
         set_word(3, 16'(16'h5000 + n));
         #1;
         got = req_ready[3];
         next_cycle();
         if (got) n++;
         if (n >= 10) req_valid = '0;
         c++;
      end
      req_valid = '0;
      n_vec++; if (n != 10) begin n_err++; $display("FAIL stats_words got=%0d exp=10 within 60 cycles", n); end
      stat_sel = 2'd3;
      next_cycle();
      n_vec++; if (stat_count !== 16'd10) begin n_err++; $display("FAIL stats_req3 got=%0d exp=10", stat_count); end
      stat_sel = 2'd0;
      next_cycle();
      n_vec++; if (stat_count !== 16'd0) begin n_err++; $display("FAIL stats_req0 got=%0d exp=0", stat_count); end
      stat_sel = 2'd3;
      next_cycle();
      reset_n = 1'b0;
      #2;
      n_vec++; if (stat_count !== 16'd0) begin n_err++; $display("FAIL stats_reset got=%0d exp=0", stat_count); end
      reset_n = 1'b1;
      next_cycle();
      next_cycle();
      n_vec++; if (stat_count !== 16'd0) begin n_err++; $display("FAIL stats_cleared got=%0d exp=0", stat_count); end
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_req();
      test_round_robin();
      test_full_stall();
      test_drop_valid();
`ifdef FIFO_WR_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
